// File: rtl/minmax_tracker_pkg.sv
// minmax_tracker_pkg: shared state encoding, defaults and comparator flag type
package minmax_tracker_pkg;
   localparam int N_SAMPLES_DEF = 8;
   localparam int CNT_W_DEF = 4;
   localparam int DATA_W = 4;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRST = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_t;
endpackage

// File: rtl/minmax_tracker_cmp.sv
// minmax_tracker_cmp: 4-bit unsigned magnitude comparator (a vs b)
module minmax_tracker_cmp
   import minmax_tracker_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output cmp_t              f
);
   assign f = '{eq: a == b, gt: a > b, lt: a < b};
endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame running max/min with first-occurrence indices and max count
module minmax_tracker
   import minmax_tracker_pkg::*;
#(
   parameter int N_SAMPLES = N_SAMPLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W-1:0] min_out,
   output logic [CNT_W-1:0]  max_idx,
   output logic [CNT_W-1:0]  min_idx,
   output logic [CNT_W-1:0]  max_cnt,
   output logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done
);
   state_t state, state_nx;
   cmp_t max_f, min_f;
   logic accept, clear, cmp_unused;

   minmax_tracker_cmp u_cmp_max (.a(in_data), .b(max_out), .f(max_f));
   minmax_tracker_cmp u_cmp_min (.a(in_data), .b(min_out), .f(min_f));

   assign busy = (state == ST_FIRST) || (state == ST_RUN);
   assign in_ready = busy;
   assign done = state == ST_DONE;
   assign accept = in_valid && in_ready;
   assign clear = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign cmp_unused = max_f.lt | min_f.gt | min_f.eq;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_FIRST;
         ST_FIRST: if (accept) state_nx = (N_SAMPLES == 1) ? ST_DONE : ST_RUN;
         ST_RUN:   if (accept && count == CNT_W'(N_SAMPLES - 1)) state_nx = ST_DONE;
         default:  state_nx = start ? ST_FIRST : ST_IDLE;
      endcase
   end

   // max/min values survive the frame-start clear so results hold until the first new sample
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         max_out <= '0;
         min_out <= '0;
         max_idx <= '0;
         min_idx <= '0;
         max_cnt <= '0;
         count   <= '0;
      end else if (clear) begin
         max_idx <= '0;
         min_idx <= '0;
         max_cnt <= '0;
         count   <= '0;
      end else if (accept && state == ST_FIRST) begin
         max_out <= in_data;
         min_out <= in_data;
         max_idx <= '0;
         min_idx <= '0;
         max_cnt <= CNT_W'(1);
         count   <= CNT_W'(1);
      end else if (accept) begin
         count <= count + CNT_W'(1);
         if (max_f.gt) begin
            max_out <= in_data;
            max_idx <= count;
            max_cnt <= CNT_W'(1);
         end else if (max_f.eq) max_cnt <= max_cnt + CNT_W'(1);
         if (min_f.lt) begin
            min_out <= in_data;
            min_idx <= count;
         end
      end
endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Sequential consumer of the 4-bit magnitude comparator flags (equal/greater/lesser).
- Accepts a stream of N_SAMPLES 4-bit samples over a valid/ready handshake and tracks the running maximum and minimum, their first-occurrence indices, and how many times the final maximum occurred.
- Sits downstream of the comparator stage in the lab datapath.
- Pulses done when a frame completes.

Parameters:
- N_SAMPLES, 8, samples per frame; legal range 1..15.
- CNT_W, 4, width of sample counter, indices and max_cnt; must satisfy 2^CNT_W > N_SAMPLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new frame; honoured only in IDLE or DONE.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  4  unsigned sample.
- in_ready  output  1  block accepts a sample this cycle; high in FIRST and RUN only.
- max_out  output  4  running/final maximum.
- min_out  output  4  running/final minimum.
- max_idx  output  CNT_W  frame index (0-based) of the first occurrence of max_out.
- min_idx  output  CNT_W  frame index of the first occurrence of min_out.
- max_cnt  output  CNT_W  occurrences of the current max_out so far.
- count  output  CNT_W  samples accepted in the current frame.
- busy  output  1  high in FIRST and RUN.
- done  output  1  one-cycle pulse, high in DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0, including in_ready, busy and done. Takes effect immediately, including mid-frame. The partial frame is discarded, and no done pulse is produced for it.
- A sample is accepted on a rising edge where in_valid && in_ready. All registers update on that edge; there is no combinational path from in_data to any output.
- IDLE:
  - in_ready=0.
  - start=1 -> FIRST; count, max_cnt and indices cleared to 0 on that edge.
  - max_out and min_out keep their last values until the first sample of the new frame.
- FIRST:
  - On accept: max_out=min_out=in_data, max_idx=min_idx=0, max_cnt=1, count=1.
  - Next state is DONE if N_SAMPLES==1, else RUN.
  - No accept -> stay in FIRST.
- RUN (on accept, with i = current count value used as the sample index):
  - Two comparator instances are evaluated against max_out and min_out respectively.
  - If in_data > max_out: max_out=in_data, max_idx=i, max_cnt=1.
  - Else if in_data == max_out: max_cnt+=1; max_idx unchanged (first occurrence wins).
  - If in_data < min_out: min_out=in_data, min_idx=i.
  - Ties on min leave min_idx unchanged.
  - Max and min updates are independent and may happen on the same edge.
  - count+=1. The edge that accepts sample index N_SAMPLES-1 moves to DONE.
  - No accept -> hold all state.
- DONE:
  - done=1 for exactly one cycle; results are stable and valid from this cycle.
  - Next: FIRST if start=1 (back-to-back frames), else IDLE.
  - Results hold in IDLE until the next frame's first accept.
- start in FIRST or RUN is ignored; the frame continues.
- Width/arithmetic: all comparisons are unsigned 4-bit. Counters never wrap, because max_cnt and count are ≤ N_SAMPLES < 2^CNT_W.
- Boundaries: samples of 0 and 15 must update min and max correctly, with no special case. A frame where all samples are equal gives max_cnt=N_SAMPLES and both indices 0.
- Latency: done is asserted the cycle after the edge that accepts the last sample. in_data is never stalled beyond in_ready rules.

Decomposition:
- Shared package (or include file) holds:
  - the state encoding constants ST_IDLE=2'd0, ST_FIRST=2'd1, ST_RUN=2'd2, ST_DONE=2'd3;
  - the default N_SAMPLES and CNT_W.
- Sub-module: reuse the existing 4-bit comparator, two instances (sample vs max_out, sample vs min_out). The top contains only the FSM, counters and registers.

Test Plan:
- Reset, then start, then stream 5,9,2,9,2,15,0,7 with in_valid held high. Required: done pulses 1 cycle after the 8th accept, max_out=15, max_idx=5, max_cnt=1, min_out=0, min_idx=6, count=8.
- Stream 4,9,1,9,9,1,2,9. Required: max_out=9, max_idx=1, max_cnt=4, min_out=1, min_idx=2 (tie at index 5 ignored).
- All samples 3, with in_valid toggled 1/0 every other cycle. Required:
  - no accept while in_valid=0;
  - done after 8 accepts;
  - max_out=min_out=3, both indices 0, max_cnt=8.
- Assert rst for one cycle after 4 samples of a frame. Required: all outputs 0 immediately, state IDLE, in_ready=0, and no done pulse. A subsequent start plus a full frame yields correct results.
- start pulsed during RUN is ignored. start held high during DONE goes directly to FIRST: in_ready=1 the next cycle, and the second frame (15,15,...,0) gives max_cnt=7, min_idx=7.
- With N_SAMPLES=1, start then a single sample 10. Required: FIRST -> DONE, done=1 the next cycle, max_out=min_out=10, max_cnt=1, count=1.
